// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS control tokens, FSM state encoding and data-character decode
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } tmds_state_e;

  function automatic logic is_token(input logic [9:0] d);
    return (d == TOKEN_C00) || (d == TOKEN_C01) || (d == TOKEN_C10) || (d == TOKEN_C11);
  endfunction

  function automatic logic [1:0] token_c(input logic [9:0] d);
    logic [1:0] r;
    case (d)
      TOKEN_C01: r = 2'b01;
      TOKEN_C10: r = 2'b10;
      TOKEN_C11: r = 2'b11;
      default:   r = 2'b00;
    endcase
    return r;
  endfunction

  // Undo the optional inversion (bit 9), then the XOR/XNOR chain selected by bit 8.
  function automatic logic [7:0] tmds_decode(input logic [9:0] d);
    logic [7:0] q;
    logic [7:0] r;
    q    = d[9] ? ~d[7:0] : d[7:0];
    r[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      r[i] = d[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return r;
  endfunction

endpackage

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - one TMDS channel: word alignment via bitslip search and 2-stage character decode
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_RUN     = 8,
  parameter int SLIP_TIMEOUT = 1024,
  parameter int SLIP_WAIT    = 16,
  parameter int LOSS_TIMEOUT = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  output logic       bitslip,
  output logic       aligned,
  output logic       de,
  output logic [1:0] c,
  output logic [7:0] dout
);

  localparam int TMAX_A = (SLIP_TIMEOUT > SLIP_WAIT) ? SLIP_TIMEOUT : SLIP_WAIT;
  localparam int TMAX   = (LOSS_TIMEOUT > TMAX_A) ? LOSS_TIMEOUT : TMAX_A;
  localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int RW     = $clog2(LOCK_RUN + 1);

  localparam logic [1:0] SEARCH = ST_SEARCH;
  localparam logic [1:0] SLIP   = ST_SLIP;
  localparam logic [1:0] WAIT   = ST_WAIT;
  localparam logic [1:0] LOCKED = ST_LOCKED;

  logic [9:0]    d1;
  logic [RW-1:0] run, run_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [1:0]    state, state_nxt;
  logic          tok1, run_full;

  assign tok1     = is_token(d1);
  assign run_full = (run == RW'(LOCK_RUN));

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    run_nxt   = !tok1 ? '0 : (run_full ? run : run + RW'(1));
    case (state)
      SEARCH: begin
        // A completed token run takes priority over a due slip.
        if (run_full) begin
          state_nxt = LOCKED;
          timer_nxt = '0;
        end else if (timer == TW'(SLIP_TIMEOUT - 1)) begin
          state_nxt = SLIP;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      SLIP: begin
        state_nxt = WAIT;
        timer_nxt = '0;
        run_nxt   = '0;
      end
      WAIT: begin
        run_nxt = '0;
        if (timer == TW'(SLIP_WAIT - 1)) begin
          state_nxt = SEARCH;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: begin
        if (run_full) begin
          timer_nxt = '0;
        end else if (timer == TW'(LOSS_TIMEOUT - 1)) begin
          state_nxt = SEARCH;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
    endcase
  end

  // Outputs are qualified by the next state so they never lag aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1      <= '0;
      run     <= '0;
      timer   <= '0;
      state   <= SEARCH;
      aligned <= 1'b0;
      bitslip <= 1'b0;
      de      <= 1'b0;
      c       <= 2'b00;
      dout    <= 8'h00;
    end else begin
      d1      <= din;
      run     <= run_nxt;
      timer   <= timer_nxt;
      state   <= state_nxt;
      aligned <= (state_nxt == LOCKED);
      bitslip <= (state_nxt == SLIP);
      if (state_nxt != LOCKED) begin
        de   <= 1'b0;
        c    <= 2'b00;
        dout <= 8'h00;
      end else if (tok1) begin
        de   <= 1'b0;
        c    <= token_c(d1);
        dout <= 8'h00;
      end else begin
        de   <= 1'b1;
        dout <= tmds_decode(d1);
      end
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - directed self-checking bench for tmds_decoder
module tb_tmds_decoder;

  localparam int LOCK_RUN     = 8;
  localparam int SLIP_TIMEOUT = 64;
  localparam int SLIP_WAIT    = 16;
  localparam int LOSS_TIMEOUT = 256;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam logic [9:0] DATA0 = 10'b0100000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] din = '0;
  logic       bitslip, aligned, de;
  logic [1:0] c;
  logic [7:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tmds_decoder #(
    .LOCK_RUN    (LOCK_RUN),
    .SLIP_TIMEOUT(SLIP_TIMEOUT),
    .SLIP_WAIT   (SLIP_WAIT),
    .LOSS_TIMEOUT(LOSS_TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (din),
    .bitslip(bitslip),
    .aligned(aligned),
    .de     (de),
    .c      (c),
    .dout   (dout)
  );

  function automatic logic [9:0] rot(input logic [9:0] w, input int k);
    logic [19:0] x;
    x = {w, w};
    return x[k +: 10];
  endfunction

  // Leaves the bench at the negedge where rst_n rises, with din = d0.
  task automatic do_reset(input logic [9:0] d0);
    @(negedge clk);
    rst_n = 1'b0;
    din   = d0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (aligned !== 1'b0) begin n_fail++; $display("FAIL reset_aligned: got %b expected 0", aligned); end
    n_checks++; if (bitslip !== 1'b0) begin n_fail++; $display("FAIL reset_bitslip: got %b expected 0", bitslip); end
    n_checks++; if ({de, c, dout} !== 11'h0) begin n_fail++; $display("FAIL reset_outputs: got de=%b c=%b dout=%h expected all 0", de, c, dout); end
    repeat (3) @(negedge clk);
    n_checks++; if ({bitslip, aligned, de, c, dout} !== 13'h0) begin n_fail++; $display("FAIL reset_held: got bs=%b al=%b de=%b c=%b dout=%h expected all 0", bitslip, aligned, de, c, dout); end
    rst_n = 1'b1;
  endtask

  task automatic test_lock;
    do_reset(TOK00);
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == 9) begin
        n_checks++; if (aligned !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %b expected 0", aligned); end
      end
      if (j == 10) begin
        n_checks++; if (aligned !== 1'b1) begin n_fail++; $display("FAIL lock_aligned: got %b expected 1", aligned); end
        n_checks++; if ({de, c, dout} !== 11'h0) begin n_fail++; $display("FAIL lock_token_out: got de=%b c=%b dout=%h expected de=0 c=00 dout=00", de, c, dout); end
        n_checks++; if (bitslip !== 1'b0) begin n_fail++; $display("FAIL lock_bitslip: got %b expected 0", bitslip); end
      end
    end
  endtask

  task automatic test_decode;
    logic [9:0] vec [8];
    logic [10:0] exp [8];
    vec[0] = 10'b0101010100; exp[0] = {1'b0, 2'b10, 8'h00};
    vec[1] = 10'b0100000000; exp[1] = {1'b1, 2'b10, 8'h00};
    vec[2] = 10'b1011111111; exp[2] = {1'b1, 2'b10, 8'hFE};
    vec[3] = 10'b0111110000; exp[3] = {1'b1, 2'b10, 8'h10};
    vec[4] = 10'b1000000001; exp[4] = {1'b1, 2'b10, 8'hFC};
    vec[5] = 10'b0010101011; exp[5] = {1'b0, 2'b01, 8'h00};
    vec[6] = 10'b0001010101; exp[6] = {1'b1, 2'b01, 8'h01};
    vec[7] = 10'b1010101011; exp[7] = {1'b0, 2'b11, 8'h00};
    for (int k = 0; k <= 8; k++) begin
      din = (k < 8) ? vec[k] : TOK00;
      @(negedge clk);
      if (k >= 1) begin
        n_checks++;
        if ({de, c, dout} !== exp[k-1]) begin
          n_fail++;
          $display("FAIL decode_%0d: got de=%b c=%b dout=%h expected de=%b c=%b dout=%h",
                   k - 1, de, c, dout, exp[k-1][10], exp[k-1][9:8], exp[k-1][7:0]);
        end
        n_checks++; if (aligned !== 1'b1) begin n_fail++; $display("FAIL decode_aligned_%0d: got %b expected 1", k - 1, aligned); end
      end
    end
  endtask

  task automatic test_loss;
    din = TOK00;
    repeat (10) @(negedge clk);
    din = DATA0;
    for (int j = 1; j <= LOSS_TIMEOUT + 2 + SLIP_TIMEOUT; j++) begin
      @(negedge clk);
      if (j == LOSS_TIMEOUT + 1) begin
        n_checks++; if ({aligned, de} !== 2'b11) begin n_fail++; $display("FAIL loss_before: got al=%b de=%b expected al=1 de=1", aligned, de); end
      end
      if (j == LOSS_TIMEOUT + 2) begin
        n_checks++; if ({aligned, de, c, dout} !== 12'h0) begin n_fail++; $display("FAIL loss_drop: got al=%b de=%b c=%b dout=%h expected all 0", aligned, de, c, dout); end
      end
      if (j >= LOSS_TIMEOUT + 2 && j < LOSS_TIMEOUT + 2 + SLIP_TIMEOUT) begin
        n_checks++; if (bitslip !== 1'b0) begin n_fail++; $display("FAIL loss_early_slip at %0d: got %b expected 0", j, bitslip); end
      end
      if (j == LOSS_TIMEOUT + 2 + SLIP_TIMEOUT) begin
        n_checks++; if (bitslip !== 1'b1) begin n_fail++; $display("FAIL loss_slip: got %b expected 1", bitslip); end
      end
    end
  endtask

  task automatic test_slip;
    int ofs;
    int np;
    int p [4];
    ofs = 3;
    np  = 0;
    p   = '{0, 0, 0, 0};
    do_reset(rot(TOK00, 3));
    for (int j = 1; j <= 300; j++) begin
      @(negedge clk);
      if (bitslip) begin
        if (np < 4) p[np] = j;
        np++;
        if (ofs > 0) ofs--;
        din = rot(TOK00, ofs);
      end
      if (j == 251) begin
        n_checks++; if (aligned !== 1'b0) begin n_fail++; $display("FAIL slip_early_lock: got %b expected 0", aligned); end
      end
      if (j == 252) begin
        n_checks++; if (aligned !== 1'b1) begin n_fail++; $display("FAIL slip_lock: got %b expected 1", aligned); end
      end
    end
    n_checks++; if (np !== 3) begin n_fail++; $display("FAIL slip_count: got %0d expected 3", np); end
    n_checks++; if (p[0] !== SLIP_TIMEOUT) begin n_fail++; $display("FAIL slip_first: got %0d expected %0d", p[0], SLIP_TIMEOUT); end
    n_checks++; if (p[1] - p[0] !== SLIP_TIMEOUT + SLIP_WAIT + 1) begin n_fail++; $display("FAIL slip_gap1: got %0d expected %0d", p[1] - p[0], SLIP_TIMEOUT + SLIP_WAIT + 1); end
    n_checks++; if (p[2] - p[1] !== SLIP_TIMEOUT + SLIP_WAIT + 1) begin n_fail++; $display("FAIL slip_gap2: got %0d expected %0d", p[2] - p[1], SLIP_TIMEOUT + SLIP_WAIT + 1); end
  endtask

  task automatic test_reset_mid_slip;
    do_reset(rot(TOK00, 3));
    for (int j = 1; j <= SLIP_TIMEOUT; j++) begin
      @(negedge clk);
      if (j == SLIP_TIMEOUT) begin
        n_checks++; if (bitslip !== 1'b1) begin n_fail++; $display("FAIL rslip_pulse: got %b expected 1", bitslip); end
      end
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if ({bitslip, aligned, de, c, dout} !== 13'h0) begin n_fail++; $display("FAIL rslip_async: got bs=%b al=%b de=%b c=%b dout=%h expected all 0", bitslip, aligned, de, c, dout); end
    repeat (3) begin
      @(negedge clk);
      n_checks++; if (bitslip !== 1'b0) begin n_fail++; $display("FAIL rslip_held: got %b expected 0", bitslip); end
    end
    rst_n = 1'b1;
    for (int j = 1; j <= SLIP_TIMEOUT; j++) begin
      @(negedge clk);
      if (j < SLIP_TIMEOUT) begin
        n_checks++; if (bitslip !== 1'b0) begin n_fail++; $display("FAIL rslip_after at %0d: got %b expected 0", j, bitslip); end
      end else begin
        n_checks++; if (bitslip !== 1'b1) begin n_fail++; $display("FAIL rslip_next: got %b expected 1", bitslip); end
      end
    end
  endtask

  task automatic test_reset_mid_locked;
    do_reset(TOK11);
    repeat (12) @(negedge clk);
    n_checks++; if ({aligned, c} !== 3'b111) begin n_fail++; $display("FAIL rlock_pre: got al=%b c=%b expected al=1 c=11", aligned, c); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if ({bitslip, aligned, de, c, dout} !== 13'h0) begin n_fail++; $display("FAIL rlock_async: got bs=%b al=%b de=%b c=%b dout=%h expected all 0", bitslip, aligned, de, c, dout); end
    @(negedge clk);
    rst_n = 1'b1;
    din   = DATA0;
    repeat (4) begin
      @(negedge clk);
      n_checks++; if ({bitslip, aligned} !== 2'b00) begin n_fail++; $display("FAIL rlock_after: got bs=%b al=%b expected 0 0", bitslip, aligned); end
    end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_decode;
    test_loss;
    test_slip;
    test_reset_mid_slip;
    test_reset_mid_locked;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
